gpio_bank: RTL and testbench
============================

Name: gpio_bank

Overview:
Parametrised successor to the single-pair 8-bit I/O port: NUM_PORTS independent ports of WIDTH bits, each with output data register, data direction register, rising-edge interrupt flags and enable mask.
Sits on the same enable/we_n/A/DI/DO/OE register bus as the existing I/O block.
Drives a single level interrupt line to the CPU glue.
Pin inputs are treated as asynchronous and synchronised inside the block.

Parameters:
NUM_PORTS, 2, number of ports; legal 1..8.
WIDTH, 8, bits per port; legal 1..32.
SYNC_STAGES, 2, input synchroniser depth; legal >=2; used only when GPIO_SYNC_EN is defined.
AW (localparam), clog2(NUM_PORTS)+2, address width; minimum 2.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  bus access strobe for the current cycle.
we_n  input  1  0 = write, 1 = read.
A  input  AW  register address: A[AW-1:2] = port index, A[1:0] = register offset.
DI  input  WIDTH  write data.
DO  output  WIDTH  registered read data.
OE  output  1  read-data valid; drives the external bus.
PO  output  NUM_PORTS*WIDTH  output data; port p occupies bits [p*WIDTH +: WIDTH].
PI  input  NUM_PORTS*WIDTH  raw pin inputs; same packing as PO.
DDR  output  NUM_PORTS*WIDTH  pin output enables; 1 = output.
irq  output  1  interrupt request, level, active high.

Behaviour:
- Reset value of every register is 0: PO, DDR, IER, IFR, DO, OE, synchroniser stages and the edge-detect "prev" register. irq = 0.
- Register offsets per port:
  - 0 DATA: write sets PO; read returns merged value.
  - 1 DDR: read/write.
  - 2 IER: read/write.
  - 3 IFR: read returns flags; write is write-1-to-clear.
- Merged DATA read, per bit: DDR ? PO : synchronised pin.
- Writes commit on the clock edge where enable=1, we_n=0 and the port index is < NUM_PORTS. OE is 0 on that edge.
- Reads:
  - OE <= enable & we_n & (port index < NUM_PORTS), evaluated every cycle.
  - DO loads the selected register on a valid read and holds otherwise.
  - Read latency is 1 cycle: DO/OE are valid the cycle after the strobe.
  - Reads have no side effects, including reads of IFR.
- Out-of-range port index: no state change; OE <= 0.
- Edge detect, per bit:
  - cur = synchronised pin; prev <= cur every cycle.
  - IFR bit set when cur & ~prev & ~DDR.
  - Flags are set regardless of IER.
  - Pins configured as outputs never set flags.
- A new edge and a W1C write on the same bit in the same cycle: set wins.
- A write to DDR takes effect on the next cycle's edge evaluation.
- irq = OR over all ports of |(IFR & IER), driven combinationally from registers (glitch-free).
- Latency from pin rise to IFR set is SYNC_STAGES+1 clock edges.
- rst asserted mid-access: everything returns to reset values immediately; the pending read is dropped (OE=0).

Optional Feature:
GPIO_SYNC_EN
- Defined: each PI bit passes through a SYNC_STAGES-flop synchroniser before prev/cur. Edge latency = SYNC_STAGES+1.
- Undefined: a single sample register (SYNC_STAGES ignored), for pins already synchronous to clk. Edge latency = 2 edges.
- The register map is identical in both builds.

Decomposition:
- Package gpio_pkg: register offset constants REG_DATA=2'd0, REG_DDR=2'd1, REG_IER=2'd2, REG_IFR=2'd3; function computing AW from NUM_PORTS.
- Sub-module gpio_port holds one port: PO/DDR/IER/IFR registers, synchroniser, edge detect, merged read value. It is generated NUM_PORTS times.
- The top level performs address decode, read mux, DO/OE registration and the irq OR.

Test Plan:
- Reset: run traffic, assert rst mid-read -> same cycle DO=0, OE=0, PO=0, DDR=0, irq=0; writes ignored while rst=1.
- Merged read: write A=1 DI=0xF0, A=0 DI=0xA5, PI port0=0x3C, wait sync; read A=0 -> next cycle DO=0xAC, OE=1; following idle cycle OE=0, DO holds 0xAC.
- Interrupt path: A=2 DI=0x01, PI[0] 0->1 -> IFR0=0x01 after SYNC_STAGES+1 edges, irq=1; write A=3 DI=0x01 -> IFR0=0x00, irq=0. With IER=0 -> flag sets, irq stays 0.
- Set-wins collision: IFR0 bit0=1; issue W1C A=3 DI=0x01 on the cycle a new rising edge is detected -> IFR0 bit0 remains 1.
- Output pins masked: DDR0=0xFF, toggle PI0 and PO0 0x00->0xFF -> IFR0 stays 0x00. Port1 at A=4..7 unaffected by port0 writes.
- NUM_PORTS=3 build: read/write A=12..15 -> OE=0, no register changes. Port2 at A=8..11 fully functional.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_bank shared definitions: register offsets and address-width helper.
// Optional input synchroniser is selected with the GPIO_SYNC_EN macro.
package gpio_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_DDR  = 2'd1;
  localparam logic [1:0] REG_IER  = 2'd2;
  localparam logic [1:0] REG_IFR  = 2'd3;

  function automatic int calc_aw(input int n);
    return $clog2(n) + 2;
  endfunction

endpackage

// File: rtl/gpio_port.sv
// One GPIO port: PO/DDR/IER/IFR, pin sampler, rising-edge detect, read mux.
// GPIO_SYNC_EN selects a SYNC_STAGES-deep synchroniser instead of one sample flop.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [1:0]       off,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] po,
  output logic [WIDTH-1:0] ddr,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

`ifdef GPIO_SYNC_EN
  localparam int DEPTH = SYNC_STAGES;
`else
  // pins already synchronous: stage count is deliberately ignored
  localparam int DEPTH = 1 + 0 * SYNC_STAGES;
`endif

  logic [WIDTH-1:0] sync_q [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] ier;
  logic [WIDTH-1:0] ifr;
  logic [WIDTH-1:0] ifr_keep;

  assign cur  = sync_q[DEPTH-1];
  assign rise = cur & ~prev & ~ddr;

  always_comb begin
    ifr_keep = ifr;
    if (wr && off == REG_IFR)
      ifr_keep = ifr & ~wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        sync_q[i] <= '0;
      prev <= '0;
      po   <= '0;
      ddr  <= '0;
      ier  <= '0;
      ifr  <= '0;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < DEPTH; i++)
        sync_q[i] <= sync_q[i-1];
      prev <= cur;
      // a new edge beats a same-cycle clear
      ifr  <= ifr_keep | rise;
      if (wr) begin
        case (off)
          REG_DATA: po  <= wdata;
          REG_DDR:  ddr <= wdata;
          REG_IER:  ier <= wdata;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (off)
      REG_DATA: rdata = (ddr & po) | (~ddr & cur);
      REG_DDR:  rdata = ddr;
      REG_IER:  rdata = ier;
      REG_IFR:  rdata = ifr;
    endcase
  end

  assign irq = |(ifr & ier);

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank top: address decode, read mux, registered DO/OE, irq OR.
// Build with GPIO_SYNC_EN to synchronise pins through SYNC_STAGES flops.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter  int NUM_PORTS   = 2,
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = calc_aw(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       we_n,
  input  logic [AW-1:0]              A,
  input  logic [WIDTH-1:0]           DI,
  output logic [WIDTH-1:0]           DO,
  output logic                       OE,
  output logic [NUM_PORTS*WIDTH-1:0] PO,
  input  logic [NUM_PORTS*WIDTH-1:0] PI,
  output logic [NUM_PORTS*WIDTH-1:0] DDR,
  output logic                       irq
);

  logic [AW-1:0]    idx;
  logic             hit;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] rsel;
  logic [WIDTH-1:0] rdata_v [NUM_PORTS];
  logic [NUM_PORTS-1:0] irq_v;

  assign idx = A >> 2;
  assign hit = int'(idx) < NUM_PORTS;
  assign wr  = enable & ~we_n & hit;
  assign rd  = enable & we_n & hit;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gpio_port #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr && int'(idx) == p),
      .off   (A[1:0]),
      .wdata (DI),
      .pin   (PI[p*WIDTH +: WIDTH]),
      .po    (PO[p*WIDTH +: WIDTH]),
      .ddr   (DDR[p*WIDTH +: WIDTH]),
      .rdata (rdata_v[p]),
      .irq   (irq_v[p])
    );
  end

  always_comb begin
    rsel = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (int'(idx) == p)
        rsel = rdata_v[p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DO <= '0;
      OE <= 1'b0;
    end else begin
      OE <= rd;
      if (rd)
        DO <= rsel;
    end
  end

  assign irq = |irq_v;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (3 ports x 8 bits) against a
// per-edge behavioural model; directed plan steps then random traffic.
module tb_gpio_bank;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int AW = 4;
`ifdef GPIO_SYNC_EN
  localparam int DEPTH = SS;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          we_n;
  logic [AW-1:0] A;
  logic [W-1:0]  DI;
  logic [W-1:0]  DO;
  logic          OE;
  logic [NP*W-1:0] PO;
  logic [NP*W-1:0] PI;
  logic [NP*W-1:0] DDR;
  logic          irq;

  gpio_bank #(
    .NUM_PORTS   (NP),
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .we_n   (we_n),
    .A      (A),
    .DI     (DI),
    .DO     (DO),
    .OE     (OE),
    .PO     (PO),
    .PI     (PI),
    .DDR    (DDR),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state; h[j] = pin vector sampled j+1 edges ago
  logic [W-1:0]    m_po  [NP];
  logic [W-1:0]    m_ddr [NP];
  logic [W-1:0]    m_ier [NP];
  logic [W-1:0]    m_ifr [NP];
  logic [W-1:0]    m_do;
  logic            m_oe;
  logic [NP*W-1:0] h [0:DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_po[p] = '0; m_ddr[p] = '0; m_ier[p] = '0; m_ifr[p] = '0;
    end
    for (int j = 0; j <= DEPTH; j++) h[j] = '0;
    m_do = '0;
    m_oe = 1'b0;
  endtask

  task automatic model_edge();
    int idx;
    bit hit;
    logic [W-1:0] cur [NP];
    logic [W-1:0] rise [NP];
    logic [W-1:0] rv;
    idx = int'(A) / 4;
    hit = idx < NP;
    for (int p = 0; p < NP; p++) begin
      cur[p]  = h[DEPTH-1][p*W +: W];
      rise[p] = cur[p] & ~h[DEPTH][p*W +: W] & ~m_ddr[p];
    end
    rv = '0;
    if (hit) begin
      case (A[1:0])
        2'd0: rv = (m_ddr[idx] & m_po[idx]) | (~m_ddr[idx] & cur[idx]);
        2'd1: rv = m_ddr[idx];
        2'd2: rv = m_ier[idx];
        default: rv = m_ifr[idx];
      endcase
    end
    if (enable && !we_n && hit) begin
      case (A[1:0])
        2'd0: m_po[idx] = DI;
        2'd1: m_ddr[idx] = DI;
        2'd2: m_ier[idx] = DI;
        default: m_ifr[idx] = m_ifr[idx] & ~DI;
      endcase
    end
    for (int p = 0; p < NP; p++) m_ifr[p] = m_ifr[p] | rise[p];
    m_oe = enable && we_n && hit;
    if (m_oe) m_do = rv;
    for (int j = DEPTH; j > 0; j--) h[j] = h[j-1];
    h[0] = PI;
  endtask

  function automatic logic m_irq();
    logic r = 1'b0;
    for (int p = 0; p < NP; p++) r |= |(m_ifr[p] & m_ier[p]);
    return r;
  endfunction

  function automatic logic [NP*W-1:0] pack_po();
    logic [NP*W-1:0] v;
    for (int p = 0; p < NP; p++) v[p*W +: W] = m_po[p];
    return v;
  endfunction

  function automatic logic [NP*W-1:0] pack_ddr();
    logic [NP*W-1:0] v;
    for (int p = 0; p < NP; p++) v[p*W +: W] = m_ddr[p];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    chk("DO", 32'(DO), 32'(m_do));
    chk("OE", 32'(OE), 32'(m_oe));
    chk("PO", 32'(PO), 32'(pack_po()));
    chk("DDR", 32'(DDR), 32'(pack_ddr()));
    chk("irq", 32'(irq), 32'(m_irq()));
  endtask

  task automatic wr(input int a, input int d);
    enable = 1'b1; we_n = 1'b0; A = AW'(a); DI = W'(d);
    tick();
    enable = 1'b0; we_n = 1'b1;
  endtask

  task automatic rd(input int a);
    enable = 1'b1; we_n = 1'b1; A = AW'(a);
    tick();
    enable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; we_n = 1'b1; A = '0; DI = '0; PI = '0;
    model_reset();
    idle(2);
    chk("rst_OE", 32'(OE), 32'd0);
    chk("rst_PO", 32'(PO), 32'd0);
    @(negedge clk) rst = 1'b0;

    // port1 background pattern
    wr(5, 'h0F); wr(4, 'h33); wr(6, 'h00);

    // merged DATA read
    wr(1, 'hF0); wr(0, 'hA5);
    PI[7:0] = 8'h3C;
    idle(DEPTH + 2);
    rd(0);
    chk("merged_DO", 32'(DO), 32'hAC);
    chk("merged_OE", 32'(OE), 32'd1);
    idle(1);
    chk("hold_OE", 32'(OE), 32'd0);
    chk("hold_DO", 32'(DO), 32'hAC);

    // interrupt path with edge latency boundary
    wr(3, 'hFF); wr(2, 'h01);
    PI[7:0] = 8'h3D;
    idle(DEPTH);
    chk("irq_early", 32'(irq), 32'd0);
    idle(1);
    chk("irq_set", 32'(irq), 32'd1);
    rd(3);
    chk("ifr_set", 32'(DO), 32'h01);
    wr(3, 'h01);
    chk("irq_clr", 32'(irq), 32'd0);
    wr(2, 'h00);
    PI[7:0] = 8'h3C; idle(DEPTH + 2);
    PI[7:0] = 8'h3D; idle(DEPTH + 2);
    rd(3);
    chk("ifr_noier", 32'(DO), 32'h01);
    chk("irq_noier", 32'(irq), 32'd0);

    // clear colliding with a new edge
    PI[7:0] = 8'h3C; idle(DEPTH + 2);
    PI[7:0] = 8'h3D; idle(DEPTH);
    wr(3, 'h01);
    rd(3);
    chk("set_wins", 32'(DO), 32'h01);

    // output pins never flag
    wr(3, 'hFF); wr(1, 'hFF); wr(0, 'h00);
    PI[7:0] = 8'h00; idle(DEPTH + 2);
    PI[7:0] = 8'hFF; wr(0, 'hFF); idle(DEPTH + 2);
    rd(3);
    chk("out_mask", 32'(DO), 32'h00);
    rd(4);
    chk("port1_data", 32'(DO), 32'h03);
    rd(5);
    chk("port1_ddr", 32'(DO), 32'h0F);

    // out-of-range port index
    for (int a = 12; a < 16; a++) begin
      wr(a, 'hFF);
      rd(a);
      chk("oor_OE", 32'(OE), 32'd0);
    end

    // port2 fully functional
    wr(9, 'h0F); wr(8, 'h55);
    rd(8);
    chk("port2_data", 32'(DO), 32'h05);
    wr(10, 'hFF);
    PI[23:16] = 8'h80;
    idle(DEPTH + 1);
    chk("port2_irq", 32'(irq), 32'd1);
    rd(11);
    chk("port2_ifr", 32'(DO), 32'h80);
    wr(11, 'hFF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      enable = 1'($urandom_range(0, 1));
      we_n   = 1'($urandom_range(0, 1));
      A      = AW'($urandom_range(0, 15));
      DI     = W'($urandom);
      if ($urandom_range(0, 3) == 0) PI = (NP*W)'($urandom);
      tick();
    end
    enable = 1'b0;

    // reset asserted mid-read
    wr(2, 'hFF);
    rd(3);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_DO", 32'(DO), 32'd0);
    chk("mid_OE", 32'(OE), 32'd0);
    chk("mid_PO", 32'(PO), 32'd0);
    chk("mid_DDR", 32'(DDR), 32'd0);
    chk("mid_irq", 32'(irq), 32'd0);
    wr(0, 'hFF);
    chk("rst_wr", 32'(PO), 32'd0);
    @(negedge clk) rst = 1'b0;
    PI = '0;
    idle(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
